// File: rtl/resilient_stage_seq.sv
// Clocked sequencer for one timing-resilient stage: 4-phase left/right handshakes around a main/shadow latch pair.
// Define RESILIENT_ERR_COUNT_EN to build the saturating recovery counter on err_cnt; otherwise err_cnt reads 0.
module resilient_stage_seq #(
    parameter int WINDOW_CYCLES  = 2,
    parameter int RECOVER_CYCLES = 1,
    parameter int EVAL_TIMEOUT   = 4,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Lreq,
    output logic             Lack,
    output logic             Rreq,
    input  logic             Rack,
    input  logic             Err1,
    input  logic             Err0,
    output logic             latch_en,
    output logic             sample,
    output logic             shadow_sel,
    output logic             busy,
    output logic             err_flag,
    input  logic             err_clr,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        WINDOW,
        EVAL,
        RECOVER,
        OUT_REQ,
        OUT_RTZ
    } state_t;

    localparam logic [3:0] WIN_LOAD = 4'(WINDOW_CYCLES - 1);
    localparam logic [3:0] TMO_LOAD = 4'(EVAL_TIMEOUT - 1);
    localparam logic [3:0] REC_LOAD = 4'(RECOVER_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       lreq_q;
    logic       lack_q, lack_d;
    logic       rreq_q, rreq_d;
    logic       latch_en_q, latch_en_d;
    logic       sample_q, sample_d;
    logic       shadow_sel_q, shadow_sel_d;
    logic       busy_q, busy_d;
    logic       err_flag_q, err_flag_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_flag_d = err_flag_q;

        // One shared down-counter times the window, the EVAL timeout and the recovery.
        unique case (state_q)
            IDLE: begin
                if (Lreq && lreq_q && !lack_q) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                state_d = WINDOW;
                cnt_d   = WIN_LOAD;
            end
            WINDOW: begin
                if (cnt_q == 4'd0) begin
                    state_d = EVAL;
                    cnt_d   = TMO_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            EVAL: begin
                unique case ({Err1, Err0})
                    2'b01: state_d = OUT_REQ;
                    2'b10: begin
                        state_d = RECOVER;
                        cnt_d   = REC_LOAD;
                    end
                    2'b11: begin
                        state_d    = RECOVER;
                        cnt_d      = REC_LOAD;
                        err_flag_d = 1'b1;
                    end
                    default: begin
                        if (cnt_q == 4'd0) begin
                            state_d    = RECOVER;
                            cnt_d      = REC_LOAD;
                            err_flag_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                endcase
            end
            RECOVER: begin
                if (cnt_q == 4'd0) begin
                    state_d = OUT_REQ;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            OUT_REQ: begin
                if (Rack) begin
                    state_d = OUT_RTZ;
                end
            end
            OUT_RTZ: begin
                if (!Rack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (err_clr) begin
            err_flag_d = 1'b0;
        end

        lack_d = lack_q;
        if (state_q == IDLE && state_d == CAPTURE) begin
            lack_d = 1'b1;
        end else if (!Lreq) begin
            lack_d = 1'b0;
        end

        latch_en_d   = (state_d == CAPTURE) || (state_d == RECOVER && cnt_d == 4'd0);
        sample_d     = (state_d == EVAL);
        shadow_sel_d = (state_d == RECOVER);
        rreq_d       = (state_d == OUT_REQ);
        busy_d       = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            lreq_q       <= 1'b0;
            lack_q       <= 1'b0;
            rreq_q       <= 1'b0;
            latch_en_q   <= 1'b0;
            sample_q     <= 1'b0;
            shadow_sel_q <= 1'b0;
            busy_q       <= 1'b0;
            err_flag_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            lreq_q       <= Lreq;
            lack_q       <= lack_d;
            rreq_q       <= rreq_d;
            latch_en_q   <= latch_en_d;
            sample_q     <= sample_d;
            shadow_sel_q <= shadow_sel_d;
            busy_q       <= busy_d;
            err_flag_q   <= err_flag_d;
        end
    end

    assign Lack       = lack_q;
    assign Rreq       = rreq_q;
    assign latch_en   = latch_en_q;
    assign sample     = sample_q;
    assign shadow_sel = shadow_sel_q;
    assign busy       = busy_q;
    assign err_flag   = err_flag_q;

`ifdef RESILIENT_ERR_COUNT_EN
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             rec_entry;

    always_comb begin
        rec_entry = (state_d == RECOVER) && (state_q != RECOVER);
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = '0;
        end else if (rec_entry && err_cnt_q != {CNT_W{1'b1}}) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: doc/resilient_stage_seq.md
Name: resilient_stage_seq

Overview:
- Synchronous sequencer for one timing-resilient pipeline stage built around an error-detecting main/shadow latch pair.
- Sequence per token:
  - accept the token over a 4-phase left handshake
  - strobe the main latch and wait a fixed detection window
  - sample the dual-rail error result
  - on a timing error, insert a recovery that reloads from the shadow latch
  - release the token over a 4-phase right handshake
- Sits between the stage's upstream/downstream handshake logic and its latch/error-detector datapath. It is the clocked counterpart of the stage's handshake controller.

Parameters:
- WINDOW_CYCLES, 2, detection-window length in cycles after the latch strobe; legal range 1..15.
- RECOVER_CYCLES, 1, shadow-reload duration in cycles; legal range 1..7.
- EVAL_TIMEOUT, 4, maximum cycles to wait for a resolved error result; legal range 1..15.
- CNT_W, 8, width of the error counter (optional feature only).

Ports:
- clk  input  1  stage clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- Lreq  input  1  left request, 4-phase, synchronous to clk.
- Lack  output  1  left acknowledge.
- Rreq  output  1  right request, 4-phase.
- Rack  input  1  right acknowledge, synchronous to clk.
- Err1  input  1  detector rail: 1 = timing error.
- Err0  input  1  detector rail: 1 = clean capture.
- latch_en  output  1  main-latch load strobe.
- sample  output  1  error-detector sample enable.
- shadow_sel  output  1  main latch reloads from the shadow latch.
- busy  output  1  high whenever the state is not IDLE.
- err_flag  output  1  sticky: set on an illegal rail code (11) or an EVAL timeout.
- err_clr  input  1  synchronous clear for err_flag and err_cnt.
- err_cnt  output  CNT_W  count of recoveries.

Behaviour:
- Reset (rst=0, asynchronous):
  - state = IDLE.
  - Lack, Rreq, latch_en, sample, shadow_sel, busy, err_flag = 0; err_cnt = 0.
  - Any partial handshake is abandoned; the environment must restart from Lreq=0/Rack=0.
- All outputs are registered and decoded from the next state, so they change on the clock edge that enters a state.
- States:
  - IDLE: if Lreq=1 and Lack=0, go to CAPTURE; otherwise stay.
  - CAPTURE (1 cycle): latch_en=1; Lack is set on entry; then go to WINDOW.
  - WINDOW (exactly WINDOW_CYCLES cycles, down-counter): all strobes 0; then go to EVAL.
  - EVAL: sample=1 every cycle; decode {Err1,Err0}:
    - 01: go to OUT_REQ.
    - 10: go to RECOVER.
    - 00: stay; after EVAL_TIMEOUT cycles in EVAL, set err_flag and go to RECOVER.
    - 11: set err_flag, go to RECOVER.
  - RECOVER (RECOVER_CYCLES cycles): shadow_sel=1 in every cycle; latch_en=1 in the last cycle only; err_cnt increments once on entry; then go to OUT_REQ. No re-evaluation after recovery.
  - OUT_REQ: Rreq=1; stay until Rack=1 is sampled, then go to OUT_RTZ.
  - OUT_RTZ: Rreq=0; stay until Rack=0 is sampled, then go to IDLE.
- Left acknowledge, independent of the FSM:
  - Lack is cleared in the cycle after Lreq=0 is sampled while Lack=1.
  - The left return-to-zero may complete during WINDOW through OUT_RTZ.
  - A new capture requires both IDLE and Lack=0.
- Latency:
  - Lreq sampled high at edge N gives latch_en and Lack high after edge N+1.
  - Error-free path: Rreq rises at edge N+2+WINDOW_CYCLES+1.
  - Each recovery adds RECOVER_CYCLES.
- Boundary conditions:
  - Rack=1 while not in OUT_REQ: ignored.
  - Lreq dropping before CAPTURE: no capture occurs.
  - err_clr in the same cycle as an increment or flag set: the clear wins.
  - err_cnt saturates at all ones and does not wrap.
  - err_flag stays set until err_clr or reset.

Optional Feature:
- Macro: RESILIENT_ERR_COUNT_EN.
- Defined: err_cnt is implemented as above.
- Undefined:
  - err_cnt is tied to 0 and no counter flops exist.
  - err_clr clears only err_flag.
  - The port list is unchanged.

Test Plan:
- WINDOW_CYCLES=2. Lreq rises before edge 0 with Err=01 → latch_en high for cycle 1 only, sample high in cycle 4, Rreq high from cycle 5. After Rack 1 then 0, busy returns to 0 and err_cnt stays 0.
- Same stimulus with Err=10 at EVAL → shadow_sel high in cycle 5 with latch_en high in cycle 5; Rreq high from cycle 6; err_cnt=1; err_flag=0.
- Err held at 00 with EVAL_TIMEOUT=4 → sample high for 4 cycles, then RECOVER; err_flag=1; err_cnt=1. Then err_clr=1 for one cycle → both return to 0.
- Err=11 at EVAL → RECOVER; err_flag=1.
- Back-to-back tokens with Lreq held high and Rack slow (rises 10 cycles after Rreq):
  - no second latch_en until OUT_RTZ→IDLE and Lack=0;
  - Lack falls one cycle after Lreq falls.
- rst asserted during RECOVER → all outputs 0 immediately. After release with Lreq=1, a fresh CAPTURE occurs one cycle after the first sampling edge. With the macro undefined, 300 forced errors leave err_cnt at 0.
